pipeline_hazard_ctrl: RTL and testbench

//  Sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB). Gates PC/IFID updates,

---
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and run-state sequencer for the 5-stage pipeline: stall/flush/enable
// steering, start synchronisation, halt drain and saturating event counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             ifid_use1_i,
  input  logic             ifid_use2_i,
  input  logic             branch_taken_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_drain_next;
  logic             r_sync1, r_sync2, r_sync3;
  logic             w_start_edge;
  logic             w_hazard;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // r_sync1/r_sync2 resolve metastability; r_sync3 holds the previous level for edge detection
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= start_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_start_edge = r_sync2 & ~r_sync3;

  assign w_hazard = idex_memread_i && (idex_rd_i != 5'd0) &&
                    ((ifid_use1_i && (ifid_rs1_i == idex_rd_i)) ||
                     (ifid_use2_i && (ifid_rs2_i == idex_rd_i)));

  always_comb begin
    w_state_next  = r_state;
    w_drain_next  = r_drain_cnt;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    pc_en_o       = 1'b0;
    ifid_en_o     = 1'b0;
    ifid_flush_o  = 1'b1;
    idex_flush_o  = 1'b1;
    exmem_flush_o = 1'b1;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (w_start_edge) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken_i) begin
          // wrong-path halt/hazard is dropped along with the flushed stages
          pc_en_o     = 1'b1;
          ifid_en_o   = 1'b1;
          w_flush_inc = 1'b1;
        end else if (w_hazard) begin
          ifid_flush_o  = 1'b0;
          exmem_flush_o = 1'b0;
          w_stall_inc   = 1'b1;
        end else if (halt_i) begin
          ifid_en_o     = 1'b1;
          idex_flush_o  = 1'b0;
          exmem_flush_o = 1'b0;
          w_state_next  = ST_DRAIN;
          w_drain_next  = '0;
        end else begin
          pc_en_o       = 1'b1;
          ifid_en_o     = 1'b1;
          ifid_flush_o  = 1'b0;
          idex_flush_o  = 1'b0;
          exmem_flush_o = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (branch_taken_i) begin
          pc_en_o      = 1'b1;
          ifid_en_o    = 1'b1;
          w_flush_inc  = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          ifid_en_o     = 1'b1;
          idex_flush_o  = 1'b0;
          exmem_flush_o = 1'b0;
          if (r_drain_cnt == DRAIN_LAST) w_state_next = ST_HALT;
          else                           w_drain_next = r_drain_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a wide-counter and a 2-bit-counter instance share
// stimulus; a behavioural model is compared every cycle, plus literal spot checks.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 3;

  logic clk_i = 1'b0;
  logic rst_n = 1'b1;
  logic start_i, halt_i, idex_memread_i, ifid_use1_i, ifid_use2_i, branch_taken_i;
  logic [4:0] idex_rd_i, ifid_rs1_i, ifid_rs2_i;

  logic        pc_en_o, ifid_en_o, ifid_flush_o, idex_flush_o, exmem_flush_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;
  logic        s_pc_en_o, s_ifid_en_o, s_ifid_flush_o, s_idex_flush_o, s_exmem_flush_o;
  logic [1:0]  s_state_o;
  logic [1:0]  s_stall_cnt_o, s_flush_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DRAIN)) u_dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .halt_i(halt_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .ifid_use1_i(ifid_use1_i), .ifid_use2_i(ifid_use2_i),
    .branch_taken_i(branch_taken_i),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .ifid_flush_o(ifid_flush_o),
    .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipeline_hazard_ctrl #(.CNT_W(2), .DRAIN_CYCLES(DRAIN)) u_sat (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .halt_i(halt_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .ifid_use1_i(ifid_use1_i), .ifid_use2_i(ifid_use2_i),
    .branch_taken_i(branch_taken_i),
    .pc_en_o(s_pc_en_o), .ifid_en_o(s_ifid_en_o), .ifid_flush_o(s_ifid_flush_o),
    .idex_flush_o(s_idex_flush_o), .exmem_flush_o(s_exmem_flush_o),
    .state_o(s_state_o), .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 run, 2 drain, 3 halt; counters kept unbounded, clipped on compare
  int         m_mode = 0;
  int         m_stall = 0;
  int         m_flush = 0;
  int         m_drain_seen = 0;
  logic [2:0] m_hist = 3'b000;  // start_i as sampled at the last three edges, newest in bit 0

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic load_use();
    if (!idex_memread_i || idex_rd_i == 5'd0) return 1'b0;
    return (ifid_use1_i && ifid_rs1_i == idex_rd_i) || (ifid_use2_i && ifid_rs2_i == idex_rd_i);
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush}
  function automatic logic [4:0] exp_ctl(input int mode);
    if (mode == 1) begin
      if (branch_taken_i) return 5'b11111;
      if (load_use())     return 5'b00010;
      if (halt_i)         return 5'b01100;
      return 5'b11000;
    end
    if (mode == 2) return branch_taken_i ? 5'b11111 : 5'b01100;
    return 5'b00111;
  endfunction

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_stall <= 0; m_flush <= 0; m_drain_seen <= 0; m_hist <= 3'b000;
    end else begin
      m_hist <= {m_hist[1:0], start_i};
      case (m_mode)
        0, 3: if (m_hist[1] && !m_hist[2]) m_mode <= 1;
        1: begin
          if (branch_taken_i)  m_flush <= m_flush + 1;
          else if (load_use()) m_stall <= m_stall + 1;
          else if (halt_i) begin m_mode <= 2; m_drain_seen <= 0; end
        end
        default: begin
          if (branch_taken_i) begin m_mode <= 1; m_flush <= m_flush + 1; end
          else if (m_drain_seen + 1 == DRAIN) m_mode <= 3;
          else m_drain_seen <= m_drain_seen + 1;
        end
      endcase
    end
  end

  always @(negedge clk_i) begin
    chk("cyc_ctl", {27'd0, pc_en_o, ifid_en_o, ifid_flush_o, idex_flush_o, exmem_flush_o},
        {27'd0, exp_ctl(m_mode)});
    chk("cyc_state", {30'd0, state_o}, m_mode);
    chk("cyc_stall", {16'd0, stall_cnt_o}, sat(m_stall, 16));
    chk("cyc_flush", {16'd0, flush_cnt_o}, sat(m_flush, 16));
    chk("cyc_sat_ctl", {27'd0, s_pc_en_o, s_ifid_en_o, s_ifid_flush_o, s_idex_flush_o,
        s_exmem_flush_o}, {27'd0, exp_ctl(m_mode)});
    chk("cyc_sat_state", {30'd0, s_state_o}, m_mode);
    chk("cyc_sat_stall", {30'd0, s_stall_cnt_o}, sat(m_stall, 2));
    chk("cyc_sat_flush", {30'd0, s_flush_cnt_o}, sat(m_flush, 2));
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    start_i = 0; halt_i = 0; idex_memread_i = 0; ifid_use1_i = 0; ifid_use2_i = 0;
    branch_taken_i = 0; idex_rd_i = 0; ifid_rs1_i = 0; ifid_rs2_i = 0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_state", {30'd0, state_o}, 0);
    chk("rst_pc_en", {31'd0, pc_en_o}, 0);
    rst_n = 1'b1;
    tick();

    // held start: RUN after the third sampling edge, one edge only
    start_i = 1;
    tick(); tick();
    chk("start_e2_state", {30'd0, state_o}, 0);
    tick();
    chk("start_e3_state", {30'd0, state_o}, 1);
    repeat (7) tick();
    chk("start_held_state", {30'd0, state_o}, 1);
    start_i = 0;
    chk("run_pc_en", {31'd0, pc_en_o}, 1);

    // load-use through rs2
    idex_memread_i = 1; idex_rd_i = 5; ifid_rs2_i = 5; ifid_use2_i = 1;
    #1;
    chk("ld_pc_en", {31'd0, pc_en_o}, 0);
    chk("ld_ifid_en", {31'd0, ifid_en_o}, 0);
    chk("ld_idex_flush", {31'd0, idex_flush_o}, 1);
    tick();
    idex_memread_i = 0;
    #1;
    chk("ld_stall_cnt", {16'd0, stall_cnt_o}, 1);
    chk("ld_after_pc_en", {31'd0, pc_en_o}, 1);

    // rd = x0 never stalls
    idex_memread_i = 1; idex_rd_i = 0; ifid_rs2_i = 0;
    #1;
    chk("rd0_pc_en", {31'd0, pc_en_o}, 1);
    tick();
    idex_memread_i = 0;
    chk("rd0_stall_cnt", {16'd0, stall_cnt_o}, 1);

    // taken branch wins over hazard and halt
    idex_memread_i = 1; idex_rd_i = 7; ifid_rs1_i = 7; ifid_use1_i = 1; ifid_use2_i = 0;
    branch_taken_i = 1; halt_i = 1;
    #1;
    chk("br_pc_en", {31'd0, pc_en_o}, 1);
    chk("br_flushes", {29'd0, ifid_flush_o, idex_flush_o, exmem_flush_o}, 7);
    tick();
    idex_memread_i = 0; branch_taken_i = 0; halt_i = 0;
    chk("br_flush_cnt", {16'd0, flush_cnt_o}, 1);
    chk("br_stall_cnt", {16'd0, stall_cnt_o}, 1);
    chk("br_state", {30'd0, state_o}, 1);

    // halt: three drain cycles then HALT
    halt_i = 1;
    #1;
    chk("halt_pc_en", {31'd0, pc_en_o}, 0);
    chk("halt_ifid_flush", {31'd0, ifid_flush_o}, 1);
    chk("halt_idex_flush", {31'd0, idex_flush_o}, 0);
    tick();
    halt_i = 0;
    chk("drain1_state", {30'd0, state_o}, 2);
    tick(); tick();
    chk("drain3_state", {30'd0, state_o}, 2);
    tick();
    chk("halted_state", {30'd0, state_o}, 3);
    chk("halted_pc_en", {31'd0, pc_en_o}, 0);
    repeat (3) tick();

    // restart from HALT, halt again, branch in second drain cycle
    start_i = 1;
    repeat (3) tick();
    chk("restart_state", {30'd0, state_o}, 1);
    start_i = 0;
    halt_i = 1;
    tick();
    halt_i = 0;
    tick();
    branch_taken_i = 1;
    #1;
    chk("drain_br_flushes", {29'd0, ifid_flush_o, idex_flush_o, exmem_flush_o}, 7);
    chk("drain_br_pc_en", {31'd0, pc_en_o}, 1);
    tick();
    branch_taken_i = 0;
    chk("drain_br_state", {30'd0, state_o}, 1);
    chk("drain_br_flush_cnt", {16'd0, flush_cnt_o}, 2);

    // five more stalls: 2-bit counter pins at 3
    for (int i = 0; i < 5; i++) begin
      idex_memread_i = 1; idex_rd_i = 5'(i + 1); ifid_rs1_i = 5'(i + 1); ifid_use1_i = 1;
      tick();
      idex_memread_i = 0;
      tick();
    end
    chk("sat_stall_cnt", {30'd0, s_stall_cnt_o}, 3);
    chk("wide_stall_cnt", {16'd0, stall_cnt_o}, 6);

    // asynchronous reset mid-RUN, checked before any clock edge
    @(posedge clk_i);
    #3 rst_n = 1'b0;
    #1;
    chk("async_state", {30'd0, state_o}, 0);
    chk("async_pc_en", {31'd0, pc_en_o}, 0);
    chk("async_flushes", {29'd0, ifid_flush_o, idex_flush_o, exmem_flush_o}, 7);
    chk("async_stall_cnt", {16'd0, stall_cnt_o}, 0);
    chk("async_flush_cnt", {16'd0, flush_cnt_o}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // sub-cycle start glitch between edges is never sampled
    #1 start_i = 1;
    #2 start_i = 0;
    repeat (5) tick();
    chk("glitch_state", {30'd0, state_o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
